// File: rtl/char_sched_pkg.sv
// Shared types and sizing for the character-layer sprite scheduler.
package char_sched_pkg;

  localparam int unsigned N_CHAR    = 5;
  localparam int unsigned CHAR_SIZE = 16;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned OFFS_W    = $clog2(CHAR_SIZE);
  localparam int unsigned OFF_W     = 2 * OFFS_W;

  typedef logic [2:0] char_id_t;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } char_pos_t;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_SCAN = 1'b1
  } sched_state_e;

endpackage

// File: rtl/char_overlap_unit.sv
// Combinational test of one pixel against one character's bounding square.
module char_overlap_unit
  import char_sched_pkg::*;
(
  input  char_pos_t          pos,
  input  logic [COORD_W-1:0] x_cord,
  input  logic [COORD_W-1:0] y_cord,
  output logic               hit,
  output logic [OFFS_W-1:0]  x_off,
  output logic [OFFS_W-1:0]  y_off
);

  localparam logic [COORD_W:0] SizeExt = (COORD_W+1)'(CHAR_SIZE);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             in_x;
  logic             in_y;

  // One extra bit so a character near the coordinate max never wraps to 0.
  assign x_end = {1'b0, pos.x} + SizeExt;
  assign y_end = {1'b0, pos.y} + SizeExt;

  assign in_x = (x_cord >= pos.x) && ({1'b0, x_cord} < x_end);
  assign in_y = (y_cord >= pos.y) && ({1'b0, y_cord} < y_end);
  assign hit  = pos.en & in_x & in_y;

  // Low bits of the difference depend only on the low bits of the operands.
  assign x_off = x_cord[OFFS_W-1:0] - pos.x[OFFS_W-1:0];
  assign y_off = y_cord[OFFS_W-1:0] - pos.y[OFFS_W-1:0];

endmodule

// File: rtl/char_layer_scheduler.sv
// Per-pixel character-layer scheduler: shadow/active position sets, LOAD/SCAN control and a
// two-stage hit / priority pipeline feeding the sprite ROM.
module char_layer_scheduler
  import char_sched_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_pos_valid,
  output logic               o_pos_ready,
  input  logic [2:0]         i_pos_id,
  input  logic               i_pos_en,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  input  logic               i_pix_valid,
  input  logic [COORD_W-1:0] i_x_cord,
  input  logic [COORD_W-1:0] i_y_cord,
  output logic               o_pix_valid,
  output logic               o_hit,
  output logic [2:0]         o_char_id,
  output logic [OFF_W-1:0]   o_char_offset
);

  sched_state_e state_q, state_d;

  char_pos_t shadow_q [N_CHAR];
  char_pos_t shadow_d [N_CHAR];
  char_pos_t active_q [N_CHAR];

  logic                pos_wr;
  logic                pix_live;
  logic [N_CHAR-1:0]   hit_c;
  logic [OFFS_W-1:0]   x_off_c [N_CHAR];
  logic [OFFS_W-1:0]   y_off_c [N_CHAR];

  logic                s1_valid_q;
  logic [N_CHAR-1:0]   s1_hit_q;
  logic [OFF_W-1:0]    s1_off_q [N_CHAR];

  logic                win_hit;
  char_id_t            win_id;
  logic [OFF_W-1:0]    win_off;

  assign o_pos_ready = (state_q == S_LOAD);
  assign pos_wr      = i_pos_valid & o_pos_ready;
  assign pix_live    = i_pix_valid & (state_q == S_SCAN);

  always_comb begin
    state_d = state_q;
    if (i_frame_start) begin
      state_d = S_SCAN;
    end else if (i_frame_end) begin
      state_d = S_LOAD;
    end
  end

  // Out-of-range ids match no slot, so such writes are accepted and dropped.
  always_comb begin
    for (int i = 0; i < N_CHAR; i++) begin
      shadow_d[i] = shadow_q[i];
      if (pos_wr && (i_pos_id == char_id_t'(i))) begin
        shadow_d[i] = '{en: i_pos_en, x: i_pos_x, y: i_pos_y};
      end
    end
  end

  for (genvar g = 0; g < N_CHAR; g++) begin : g_char
    char_overlap_unit u_overlap (
      .pos    (active_q[g]),
      .x_cord (i_x_cord),
      .y_cord (i_y_cord),
      .hit    (hit_c[g]),
      .x_off  (x_off_c[g]),
      .y_off  (y_off_c[g])
    );
  end

  // Commit takes shadow_d so a write landing with frame_start is included.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_LOAD;
      for (int i = 0; i < N_CHAR; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if (i_frame_start) begin
        active_q <= shadow_d;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      for (int i = 0; i < N_CHAR; i++) begin
        s1_off_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= i_pix_valid;
      for (int i = 0; i < N_CHAR; i++) begin
        s1_hit_q[i] <= hit_c[i] & pix_live;
        s1_off_q[i] <= (hit_c[i] & pix_live) ? {x_off_c[i], y_off_c[i]} : '0;
      end
    end
  end

  // Scan from the highest id down so the lowest id hit is the final assignment.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    win_off = '0;
    for (int i = N_CHAR - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        win_hit = 1'b1;
        win_id  = char_id_t'(i);
        win_off = s1_off_q[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_valid   <= 1'b0;
      o_hit         <= 1'b0;
      o_char_id     <= '0;
      o_char_offset <= '0;
    end else begin
      o_pix_valid   <= s1_valid_q;
      o_hit         <= win_hit;
      o_char_id     <= win_id;
      o_char_offset <= win_off;
    end
  end

endmodule

// File: tb/tb_char_layer_scheduler.sv
// Randomized and directed bench for char_layer_scheduler against a frame-level reference model.
module tb_char_layer_scheduler;
  import char_sched_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_frame_start = 1'b0;
  logic               i_frame_end = 1'b0;
  logic               i_pos_valid = 1'b0;
  logic               o_pos_ready;
  logic [2:0]         i_pos_id = '0;
  logic               i_pos_en = 1'b0;
  logic [COORD_W-1:0] i_pos_x = '0;
  logic [COORD_W-1:0] i_pos_y = '0;
  logic               i_pix_valid = 1'b0;
  logic [COORD_W-1:0] i_x_cord = '0;
  logic [COORD_W-1:0] i_y_cord = '0;
  logic               o_pix_valid;
  logic               o_hit;
  logic [2:0]         o_char_id;
  logic [OFF_W-1:0]   o_char_offset;

  always #5 i_clk = ~i_clk;

  char_layer_scheduler dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_frame_end   (i_frame_end),
    .i_pos_valid   (i_pos_valid),
    .o_pos_ready   (o_pos_ready),
    .i_pos_id      (i_pos_id),
    .i_pos_en      (i_pos_en),
    .i_pos_x       (i_pos_x),
    .i_pos_y       (i_pos_y),
    .i_pix_valid   (i_pix_valid),
    .i_x_cord      (i_x_cord),
    .i_y_cord      (i_y_cord),
    .o_pix_valid   (o_pix_valid),
    .o_hit         (o_hit),
    .o_char_id     (o_char_id),
    .o_char_offset (o_char_offset)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: scanning flag, shadow/active sets and a two-entry output delay.
  bit m_scan;
  int m_sh_en [5], m_sh_x [5], m_sh_y [5];
  int m_ac_en [5], m_ac_x [5], m_ac_y [5];
  int e1_v, e1_h, e1_id, e1_off;
  int e2_v, e2_h, e2_id, e2_off;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0;
    for (int i = 0; i < 5; i++) begin
      m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0;
      m_ac_en[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0;
    end
    e1_v = 0; e1_h = 0; e1_id = 0; e1_off = 0;
    e2_v = 0; e2_h = 0; e2_id = 0; e2_off = 0;
  endtask

  // First (lowest id) enabled character whose square contains the pixel wins.
  task automatic model_pixel(input int x, input int y, output int h, output int id,
                             output int off);
    h = 0; id = 0; off = 0;
    for (int c = 0; c < 5; c++) begin
      if (h == 0 && m_ac_en[c] != 0 && x >= m_ac_x[c] && x < m_ac_x[c] + 16 &&
          y >= m_ac_y[c] && y < m_ac_y[c] + 16) begin
        h = 1; id = c; off = (x - m_ac_x[c]) * 16 + (y - m_ac_y[c]);
      end
    end
  endtask

  task automatic model_edge();
    int h, id, off;
    h = 0; id = 0; off = 0;
    if (i_pix_valid && m_scan) model_pixel(int'(i_x_cord), int'(i_y_cord), h, id, off);
    e2_v = e1_v; e2_h = e1_h; e2_id = e1_id; e2_off = e1_off;
    e1_v = int'(i_pix_valid); e1_h = h; e1_id = id; e1_off = off;
    if (i_pos_valid && !m_scan && i_pos_id < 3'd5) begin
      m_sh_en[i_pos_id] = int'(i_pos_en);
      m_sh_x[i_pos_id]  = int'(i_pos_x);
      m_sh_y[i_pos_id]  = int'(i_pos_y);
    end
    if (i_frame_start) begin
      m_ac_en = m_sh_en; m_ac_x = m_sh_x; m_ac_y = m_sh_y;
      m_scan = 1;
    end else if (i_frame_end) begin
      m_scan = 0;
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge, pulses cleared.
  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    check_eq("pix_valid", int'(o_pix_valid), e2_v);
    check_eq("hit", int'(o_hit), e2_h);
    check_eq("char_id", int'(o_char_id), e2_id);
    check_eq("char_offset", int'(o_char_offset), e2_off);
    check_eq("pos_ready", int'(o_pos_ready), m_scan ? 0 : 1);
    i_frame_start = 1'b0;
    i_frame_end   = 1'b0;
  endtask

  task automatic write_pos(input int id, input int en, input int x, input int y);
    i_pos_valid = 1'b1;
    i_pos_id    = 3'(id);
    i_pos_en    = 1'(en);
    i_pos_x     = COORD_W'(x);
    i_pos_y     = COORD_W'(y);
    step();
    i_pos_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_frame_start = 1'b1;
    step();
  endtask

  task automatic pulse_end();
    i_frame_end = 1'b1;
    step();
  endtask

  task automatic probe(input string tag, input int x, input int y, input int h, input int id,
                       input int off);
    i_pix_valid = 1'b1;
    i_x_cord    = COORD_W'(x);
    i_y_cord    = COORD_W'(y);
    step();
    i_pix_valid = 1'b0;
    step();
    check_eq({tag, "_hit"}, int'(o_hit), h);
    check_eq({tag, "_id"}, int'(o_char_id), id);
    check_eq({tag, "_off"}, int'(o_char_offset), off);
  endtask

  initial begin
    model_reset();
    #1 i_rst = 1'b1;
    #1;
    check_eq("rst_pix_valid", int'(o_pix_valid), 0);
    check_eq("rst_hit", int'(o_hit), 0);
    check_eq("rst_ready", int'(o_pos_ready), 1);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();

    // Basic hit and sprite corners
    write_pos(0, 1, 100, 50);
    pulse_start();
    probe("t1_origin", 100, 50, 1, 0, 0);
    probe("t1_corner", 115, 65, 1, 0, 255);
    probe("t1_right", 116, 50, 0, 0, 0);

    // Priority, then the winner disabled
    pulse_end();
    write_pos(3, 1, 108, 58);
    pulse_start();
    probe("t2_prio", 110, 60, 1, 0, 170);
    pulse_end();
    write_pos(0, 0, 100, 50);
    pulse_start();
    probe("t2_id3", 110, 60, 1, 3, 34);

    // Writes blocked while scanning
    i_pos_valid = 1'b1; i_pos_id = 3'd3; i_pos_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t3_ready_scan", int'(o_pos_ready), 0);
    end
    i_pos_valid = 1'b0;
    probe("t3_active_kept", 110, 60, 1, 3, 34);
    pulse_end();
    check_eq("t3_ready_load", int'(o_pos_ready), 1);
    write_pos(1, 1, 200, 100);
    pulse_start();
    probe("t3_new", 205, 103, 1, 1, 83);
    probe("t3_shadow_kept", 110, 60, 1, 3, 34);

    // Write coinciding with frame_start
    pulse_end();
    i_frame_start = 1'b1;
    write_pos(2, 1, 20, 20);
    probe("t4_bypass", 20, 20, 1, 2, 0);

    // Coordinate-max boundary and valid gap
    pulse_end();
    write_pos(4, 1, 1015, 10);
    pulse_start();
    probe("t5_nowrap", 0, 12, 0, 0, 0);
    i_pix_valid = 1'b1; i_x_cord = 10'd1020; i_y_cord = 10'd12;
    step();
    i_pix_valid = 1'b0;
    step();
    check_eq("t5_edge_hit", int'(o_hit), 1);
    check_eq("t5_edge_off", int'(o_char_offset), 82);
    i_pix_valid = 1'b1;
    step();
    check_eq("t5_gap_valid", int'(o_pix_valid), 0);
    check_eq("t5_gap_hit", int'(o_hit), 0);
    step();
    check_eq("t5_after_gap", int'(o_pix_valid), 1);
    i_pix_valid = 1'b0;
    step();

    // Async reset with hits in flight
    i_pix_valid = 1'b1; i_x_cord = 10'd20; i_y_cord = 10'd21;
    step();
    step();
    i_rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", int'(o_pix_valid), 0);
    check_eq("t6_rst_hit", int'(o_hit), 0);
    check_eq("t6_rst_id", int'(o_char_id), 0);
    check_eq("t6_rst_off", int'(o_char_offset), 0);
    check_eq("t6_rst_ready", int'(o_pos_ready), 1);
    i_pix_valid = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    pulse_start();
    probe("t6_cleared_a", 20, 20, 0, 0, 0);
    probe("t6_cleared_b", 0, 0, 0, 0, 0);

    // Random frames
    pulse_end();
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 12; k++) begin
        i_pos_valid = 1'($urandom_range(0, 1));
        i_pos_id    = 3'($urandom_range(0, 7));
        i_pos_en    = ($urandom_range(0, 9) < 8);
        i_pos_x     = ($urandom_range(0, 9) == 0) ? COORD_W'($urandom_range(1000, 1023))
                                                  : COORD_W'($urandom_range(0, 287));
        i_pos_y     = COORD_W'($urandom_range(0, 223));
        i_pix_valid = 1'($urandom_range(0, 1));
        i_x_cord    = COORD_W'($urandom_range(0, 1023));
        i_y_cord    = COORD_W'($urandom_range(0, 1023));
        if (k == 11) i_frame_start = 1'b1;
        step();
      end
      i_pos_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
        int c;
        c = $urandom_range(0, 4);
        i_pix_valid = ($urandom_range(0, 7) != 0);
        i_x_cord    = COORD_W'(m_ac_x[c] + $urandom_range(0, 19) - 2);
        i_y_cord    = COORD_W'(m_ac_y[c] + $urandom_range(0, 19) - 2);
        i_pos_valid = ($urandom_range(0, 9) == 0);
        i_pos_id    = 3'($urandom_range(0, 4));
        i_frame_start = ($urandom_range(0, 49) == 0);
        i_frame_end   = (k == 199) || ($urandom_range(0, 99) == 0 && i_frame_start);
        step();
      end
      i_pos_valid = 1'b0;
      i_pix_valid = 1'b0;
      step();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
